// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer: owns the PC, issues single outstanding requests to
// instruction memory, and presents {pc_o, instr_o} to the IF/ID register each cycle.
// A returned instruction that cannot be consumed is parked in a one-entry buffer (HOLD);
// a redirect with a request still in flight drains that request in DISCARD.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        cpu_stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        fetch_stall_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] req_addr_q, req_addr_n;
    logic [31:0] buf_q, buf_n;

    logic        valid;
    logic        redirect;
    logic        consume;
    logic [31:0] target_pc;
    logic [31:0] pc_next_seq;

    // Handshake qualifiers; a data-side stall freezes both redirect and consume.
    always_comb begin
        valid       = ((state == FETCH) && imem_ack_i) || (state == HOLD);
        redirect    = redirect_i && !cpu_stall_i;
        consume     = valid && !stall_i && !cpu_stall_i && !redirect;
        target_pc   = {redirect_pc_i[31:2], 2'b00};
        pc_next_seq = pc_q + PC_STEP;
    end

    // Outputs toward memory and the IF/ID register.
    always_comb begin
        imem_req_o    = (state == FETCH) || (state == DISCARD);
        imem_addr_o   = req_addr_q;
        pc_o          = pc_q;
        fetch_stall_o = !valid;
        if (state == HOLD)
            instr_o = buf_q;
        else if (valid)
            instr_o = imem_rdata_i;
        else
            instr_o = NOP_INSTR;
    end

    // Next-state logic: redirect beats consume beats capture.
    always_comb begin
        state_n    = state;
        pc_n       = pc_q;
        req_addr_n = req_addr_q;
        buf_n      = buf_q;
        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_n       = target_pc;
                    req_addr_n = target_pc;
                end else begin
                    req_addr_n = pc_q;
                end
                state_n = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    pc_n = target_pc;
                    if (imem_ack_i) begin
                        state_n    = FETCH;
                        req_addr_n = target_pc;
                    end else begin
                        // Request still in flight: keep its address and drop its data.
                        state_n = DISCARD;
                    end
                end else if (consume) begin
                    pc_n       = pc_next_seq;
                    req_addr_n = pc_next_seq;
                    state_n    = FETCH;
                end else if (imem_ack_i) begin
                    buf_n   = imem_rdata_i;
                    state_n = HOLD;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_n = target_pc;
                    if (imem_ack_i) begin
                        state_n    = FETCH;
                        req_addr_n = target_pc;
                    end
                end else if (imem_ack_i) begin
                    state_n    = FETCH;
                    req_addr_n = pc_q;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_n       = target_pc;
                    req_addr_n = target_pc;
                    state_n    = FETCH;
                end else if (consume) begin
                    pc_n       = pc_next_seq;
                    req_addr_n = pc_next_seq;
                    state_n    = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_q      <= 32'h0;
        end else begin
            state      <= state_n;
            pc_q       <= pc_n;
            req_addr_q <= req_addr_n;
            buf_q      <= buf_n;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, zero-wait fetch, hazard hold, redirect
// discard, cpu_stall blocking, multi-cycle latency, PC wrap and asynchronous reset.
module tb_if_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        cpu_stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        fetch_stall_o;

    int total = 0;
    int bad   = 0;

    if_fetch_unit dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .cpu_stall_i   (cpu_stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .instr_o       (instr_o),
        .fetch_stall_o (fetch_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs checked mid-cycle.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Full output snapshot against expected values.
    task automatic snap(input string tag, input logic req, input logic [31:0] addr,
                        input logic [31:0] pc, input logic [31:0] instr, input logic stl);
        #1;
        chk({tag, ".req"},   {31'b0, imem_req_o},    {31'b0, req});
        if (req) chk({tag, ".addr"}, imem_addr_o, addr);
        chk({tag, ".pc"},    pc_o,    pc);
        chk({tag, ".instr"}, instr_o, instr);
        chk({tag, ".stall"}, {31'b0, fetch_stall_o}, {31'b0, stl});
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; cpu_stall_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = 32'h0; imem_ack_i = 1'b0; imem_rdata_i = 32'hFFFF_FFFF;
        #2;
        snap("rst0", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        snap("rst1", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        rst_i = 1'b0;

        // 1: IDLE -> FETCH at 0x0, zero-wait ack, consume, next request 0x4
        tick();
        imem_ack_i = 1'b1; imem_rdata_i = 32'hAAAA_0001;
        snap("t1_fetch0", 1'b1, 32'h0, 32'h0, 32'hAAAA_0001, 1'b0);
        tick();
        imem_ack_i = 1'b0; imem_rdata_i = 32'h1234_5678;
        snap("t1_req4", 1'b1, 32'h4, 32'h4, 32'h0, 1'b1);

        // 2: hazard stall with ack -> HOLD, stable for 3 cycles, release consumes
        stall_i = 1'b1; imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0011;
        #1;
        snap("t2_ack", 1'b1, 32'h4, 32'h4, 32'h0000_0011, 1'b0);
        tick();
        imem_ack_i = 1'b0; imem_rdata_i = 32'hDEAD_BEEF;
        snap("t2_hold1", 1'b0, 32'h0, 32'h4, 32'h0000_0011, 1'b0);
        tick();
        snap("t2_hold2", 1'b0, 32'h0, 32'h4, 32'h0000_0011, 1'b0);
        stall_i = 1'b0;
        snap("t2_release", 1'b0, 32'h0, 32'h4, 32'h0000_0011, 1'b0);
        tick();
        snap("t2_req8", 1'b1, 32'h8, 32'h8, 32'h0, 1'b1);

        // 3: redirect to 0x103 while request to 0x8 outstanding -> DISCARD
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        tick();
        redirect_i = 1'b0;
        snap("t3_disc1", 1'b1, 32'h8, 32'h100, 32'h0, 1'b1);
        tick();
        snap("t3_disc2", 1'b1, 32'h8, 32'h100, 32'h0, 1'b1);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0BAD_0BAD;
        snap("t3_drop", 1'b1, 32'h8, 32'h100, 32'h0, 1'b1);
        tick();
        imem_ack_i = 1'b0;
        snap("t3_req100", 1'b1, 32'h100, 32'h100, 32'h0, 1'b1);

        // 4: redirect blocked by cpu_stall, takes effect once the stall drops
        cpu_stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        tick();
        snap("t4_blocked", 1'b1, 32'h100, 32'h100, 32'h0, 1'b1);
        cpu_stall_i = 1'b0;
        tick();
        redirect_i = 1'b0;
        snap("t4_taken", 1'b1, 32'h100, 32'h200, 32'h0, 1'b1);
        imem_ack_i = 1'b1;
        tick();
        imem_ack_i = 1'b0;
        snap("t4_req200", 1'b1, 32'h200, 32'h200, 32'h0, 1'b1);

        // 5: 4-cycle memory latency, address stable until ack
        tick();
        snap("t5_wait2", 1'b1, 32'h200, 32'h200, 32'h0, 1'b1);
        tick();
        snap("t5_wait3", 1'b1, 32'h200, 32'h200, 32'h0, 1'b1);
        tick();
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0055;
        snap("t5_ack", 1'b1, 32'h200, 32'h200, 32'h0000_0055, 1'b0);
        tick();
        imem_ack_i = 1'b0;
        snap("t5_req204", 1'b1, 32'h204, 32'h204, 32'h0, 1'b1);

        // wrap: redirect with low bits set wins over a same-cycle consume, then 0xFFFF_FFFC -> 0x0
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE; imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0066;
        tick();
        redirect_i = 1'b0; imem_rdata_i = 32'h0000_0077;
        snap("wr_top", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0077, 1'b0);
        tick();
        imem_ack_i = 1'b0;
        snap("wr_zero", 1'b1, 32'h0, 32'h0, 32'h0, 1'b1);
        imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0088;
        tick();
        imem_ack_i = 1'b0;
        snap("pre_rst", 1'b1, 32'h4, 32'h4, 32'h0, 1'b1);

        // 6: asynchronous reset between edges
        #2;
        rst_i = 1'b1;
        snap("t6_async", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        rst_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
